// File: rtl/ps_pkg.sv
// Shared constants for the partial-sum sequencer: PE address map, field widths,
// FSM state encoding and the order in which row-complete flags visit the PEs.
package ps_pkg;

  localparam int unsigned SRC_W      = 4;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned SLOT_W     = 2;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned COL_W      = 2;
  localparam int unsigned ENTRY_W    = 7;
  localparam int unsigned MAX_PE     = 5;
  localparam int unsigned FLAG_CNT   = 5;
  localparam int unsigned FLAG_IDX_W = 3;

  localparam logic [SRC_W-1:0] PE1_ADDR = 4'b0001;
  localparam logic [SRC_W-1:0] PE2_ADDR = 4'b0101;
  localparam logic [SRC_W-1:0] PE3_ADDR = 4'b0011;
  localparam logic [SRC_W-1:0] PE4_ADDR = 4'b0111;
  localparam logic [SRC_W-1:0] PE5_ADDR = 4'b1100;

  // Counter index i belongs to PE(i+1).
  localparam logic [SRC_W-1:0] PE_ADDR [MAX_PE] =
    '{PE1_ADDR, PE2_ADDR, PE3_ADDR, PE4_ADDR, PE5_ADDR};

  localparam logic [SRC_W-1:0] FLAG_ORDER [FLAG_CNT] =
    '{PE4_ADDR, PE3_ADDR, PE2_ADDR, PE1_ADDR, PE5_ADDR};

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_FLAG    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // One-hot counter select for a source address; all-zero means unknown source.
  function automatic logic [MAX_PE-1:0] pe_onehot(input logic [SRC_W-1:0] src);
    logic [MAX_PE-1:0] oh;
    oh = '0;
    for (int i = 0; i < MAX_PE; i++) begin
      if (src == PE_ADDR[i]) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/pe_arrival_tracker.sv
// Per-PE arrival counters for one collection round: decodes the packet source,
// applies per-PE backpressure, flags unknown sources and detects a full round.
module pe_arrival_tracker
  import ps_pkg::*;
#(
  parameter int unsigned NUM_PE = 5,
  parameter int unsigned SLOTS  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             collect_i,
  input  logic             clr_i,
  input  logic             pkt_valid_i,
  input  logic [SRC_W-1:0] pkt_src_i,
  output logic             pkt_ready_c,
  output logic             all_full_c,
  output logic             err_src_o
);

  logic [CNT_W-1:0]  cnt_q [NUM_PE];
  logic [CNT_W-1:0]  cnt_d [NUM_PE];
  logic [MAX_PE-1:0] hit_all;
  logic [NUM_PE-1:0] hit;
  logic              known;
  logic              sel_full;
  logic              take;
  logic              err_q;

  assign hit_all = pe_onehot(pkt_src_i);
  assign hit     = hit_all[NUM_PE-1:0];
  assign known   = |hit;

  // Full detection for the addressed PE and for the round as a whole.
  always_comb begin
    sel_full   = 1'b0;
    all_full_c = 1'b1;
    for (int i = 0; i < NUM_PE; i++) begin
      if (hit[i] && (cnt_q[i] >= CNT_W'(SLOTS))) sel_full = 1'b1;
      if (cnt_q[i] < CNT_W'(SLOTS)) all_full_c = 1'b0;
    end
  end

  assign pkt_ready_c = collect_i && !sel_full;
  assign take        = pkt_valid_i && pkt_ready_c;
  assign err_src_o   = err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      for (int i = 0; i < NUM_PE; i++) cnt_d[i] = '0;
    end else if (take) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (hit[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= take && !known;
    end
  end

endmodule

// File: rtl/partial_sum_sequencer.sv
// Sequences PE partial-sum collection rounds into adder accumulate commands,
// per-row completion flags to the PEs and a timestep-done request.
module partial_sum_sequencer
  import ps_pkg::*;
#(
  parameter int unsigned NUM_PE     = 5,
  parameter int unsigned SLOTS      = 3,
  parameter int unsigned ROWS       = 21,
  parameter int unsigned COLS       = 3,
  parameter int unsigned SEND_FLAGS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [SRC_W-1:0]  pkt_src,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [SLOT_W-1:0] acc_slot,
  output logic [ROW_W-1:0]  acc_row,
  output logic [COL_W-1:0]  acc_col,
  output logic              acc_first_ts,
  output logic              flag_valid,
  input  logic              flag_ready,
  output logic [SRC_W-1:0]  flag_dst,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              err_src
);

  localparam int unsigned TOTAL = ROWS * COLS;

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ENTRY_W-1:0]    entry_q, entry_d, entry_inc, tail_entry;
  logic                  first_q, first_d;
  logic [FLAG_IDX_W-1:0] fidx_q, fidx_d;
  logic                  clr_c, collect_c, all_full_c, do_tail;

  // pkt_ready must stay low while reset is asserted even though state is COLLECT.
  assign collect_c = rst_n && (state_q == ST_COLLECT);

  pe_arrival_tracker #(
    .NUM_PE (NUM_PE),
    .SLOTS  (SLOTS)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .collect_i   (collect_c),
    .clr_i       (clr_c),
    .pkt_valid_i (pkt_valid),
    .pkt_src_i   (pkt_src),
    .pkt_ready_c (pkt_ready),
    .all_full_c  (all_full_c),
    .err_src_o   (err_src)
  );

  assign entry_inc = (entry_q == ENTRY_W'(TOTAL)) ? entry_q : entry_q + ENTRY_W'(1);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    row_d      = row_q;
    col_d      = col_q;
    entry_d    = entry_q;
    first_d    = first_q;
    fidx_d     = fidx_q;
    clr_c      = 1'b0;
    do_tail    = 1'b0;
    tail_entry = entry_q;
    acc_valid  = 1'b0;
    flag_valid = 1'b0;
    done_valid = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (all_full_c) begin
          state_d = ST_ACCUM;
          slot_d  = '0;
        end
      end
      ST_ACCUM: begin
        acc_valid = 1'b1;
        if (acc_ready) begin
          entry_d = entry_inc;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            if (SEND_FLAGS != 0) begin
              state_d = ST_FLAG;
              fidx_d  = '0;
            end else begin
              do_tail    = 1'b1;
              tail_entry = entry_inc;
            end
          end else begin
            col_d      = col_q + COL_W'(1);
            do_tail    = 1'b1;
            tail_entry = entry_inc;
          end
        end
      end
      ST_FLAG: begin
        flag_valid = 1'b1;
        if (flag_ready) begin
          if (fidx_q == FLAG_IDX_W'(FLAG_CNT - 1)) do_tail = 1'b1;
          else fidx_d = fidx_q + FLAG_IDX_W'(1);
        end
      end
      ST_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          entry_d    = '0;
          first_d    = 1'b0;
          do_tail    = 1'b1;
          tail_entry = '0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    // Shared exit after an accumulate (or its flags, or a done): timestep end,
    // round end, or next slot of the same round.
    if (do_tail) begin
      if (tail_entry == ENTRY_W'(TOTAL)) begin
        state_d = ST_DONE;
      end else if (slot_q == SLOT_W'(SLOTS - 1)) begin
        state_d = ST_COLLECT;
        slot_d  = '0;
        clr_c   = 1'b1;
      end else begin
        state_d = ST_ACCUM;
        slot_d  = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      slot_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      entry_q <= '0;
      first_q <= 1'b1;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
      col_q   <= col_d;
      entry_q <= entry_d;
      first_q <= first_d;
      fidx_q  <= fidx_d;
    end
  end

  assign acc_slot     = slot_q;
  assign acc_row      = row_q;
  assign acc_col      = col_q;
  assign acc_first_ts = first_q;
  assign flag_dst     = FLAG_ORDER[fidx_q];

endmodule

// File: tb/tb_partial_sum_sequencer.sv
// Randomized bench for partial_sum_sequencer against a transaction-level model
// that derives the expected command stream from the round/entry arithmetic.
`timescale 1ns/1ps
module tb_partial_sum_sequencer;

  localparam int SLOTS = 3;
  localparam int ROWS  = 21;
  localparam int COLS  = 3;
  localparam int TOTAL = ROWS * COLS;
  localparam int M_DIRECT = 0;
  localparam int M_RANDOM = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pkt_valid, pkt_ready;
  logic [3:0] pkt_src;
  logic       acc_valid, acc_ready, acc_first_ts;
  logic [1:0] acc_slot, acc_col;
  logic [4:0] acc_row;
  logic       flag_valid, flag_ready;
  logic [3:0] flag_dst;
  logic       done_valid, done_ready, err_src;

  partial_sum_sequencer #(
    .NUM_PE(5), .SLOTS(SLOTS), .ROWS(ROWS), .COLS(COLS), .SEND_FLAGS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_src(pkt_src),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_slot(acc_slot),
    .acc_row(acc_row), .acc_col(acc_col), .acc_first_ts(acc_first_ts),
    .flag_valid(flag_valid), .flag_ready(flag_ready), .flag_dst(flag_dst),
    .done_valid(done_valid), .done_ready(done_ready), .err_src(err_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 acc, 1 flag, 2 done
    int slot;
    int row;
    int col;
    int first;
    int dst;
  } item_t;

  logic [3:0] pe_addr [5] = '{4'b0001, 4'b0101, 4'b0011, 4'b0111, 4'b1100};
  int         flag_order [5] = '{3, 2, 1, 0, 4};

  item_t      exp_q [$];
  logic [3:0] src_list [$];
  int         cnt [5];
  int         acc_seq, flag_run, stall, hold_cnt, mode;
  bit         gap, err_pend;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pe_idx(input logic [3:0] s);
    for (int i = 0; i < 5; i++) if (s == pe_addr[i]) return i;
    return -1;
  endfunction

  function automatic bit round_full();
    for (int i = 0; i < 5; i++) if (cnt[i] < SLOTS) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    acc_seq = 0; flag_run = 0; stall = 0; hold_cnt = 0;
    gap = 1'b0; err_pend = 1'b0;
  endtask

  // Expected outputs of one full round, from the global accumulate sequence number.
  task automatic push_round();
    item_t it;
    int m;
    for (int k = 0; k < SLOTS; k++) begin
      m = acc_seq % TOTAL;
      it = '{kind:0, slot:k, row:m / COLS, col:m % COLS, first:(acc_seq < TOTAL) ? 1 : 0, dst:0};
      exp_q.push_back(it);
      if (m % COLS == COLS - 1) begin
        for (int j = 0; j < 5; j++) begin
          it = '{kind:1, slot:0, row:0, col:0, first:0, dst:32'(pe_addr[flag_order[j]])};
          exp_q.push_back(it);
        end
      end
      if (m == TOTAL - 1) begin
        it = '{kind:2, slot:0, row:0, col:0, first:0, dst:0};
        exp_q.push_back(it);
      end
      acc_seq++;
    end
  endtask

  task automatic step();
    int         idx, okind;
    bit         exp_rdy, pkt_hs, out_hs, any_v;
    item_t      f;
    logic [3:0] s;
    idx = pe_idx(pkt_src);
    if (idx >= 0) exp_rdy = (cnt[idx] < SLOTS);
    else          exp_rdy = (exp_q.size() == 0) || gap;
    check_eq("pkt_ready", 32'(pkt_ready), 32'(exp_rdy));
    check_eq("err_src", 32'(err_src), 32'(err_pend));
    check_eq("vld_excl", 32'((32'(acc_valid) + 32'(flag_valid) + 32'(done_valid)) > 1), 0);
    any_v = (exp_q.size() != 0) && !gap;
    check_eq("any_valid", 32'(acc_valid | flag_valid | done_valid), 32'(any_v));
    out_hs = 1'b0;
    if (any_v) begin
      f = exp_q[0];
      okind = acc_valid ? 0 : flag_valid ? 1 : done_valid ? 2 : 3;
      check_eq("out_kind", okind, f.kind);
      if (f.kind == 0) begin
        check_eq("acc_slot", 32'(acc_slot), f.slot);
        check_eq("acc_row", 32'(acc_row), f.row);
        check_eq("acc_col", 32'(acc_col), f.col);
        check_eq("acc_first_ts", 32'(acc_first_ts), f.first);
        out_hs = acc_ready;
      end else if (f.kind == 1) begin
        check_eq("flag_dst", 32'(flag_dst), f.dst);
        out_hs = flag_ready;
      end else begin
        out_hs = done_ready;
      end
    end
    pkt_hs   = pkt_valid && exp_rdy;
    err_pend = pkt_hs && (idx < 0);
    gap      = 1'b0;
    if (pkt_hs && idx >= 0) begin
      cnt[idx]++;
      if (round_full()) begin
        push_round();
        gap = 1'b1;
      end
    end
    if (out_hs) begin
      f = exp_q.pop_front();
      flag_run = (f.kind == 1) ? flag_run + 1 : 0;
      if (exp_q.size() == 0) for (int i = 0; i < 5; i++) cnt[i] = 0;
    end
    if (mode == M_DIRECT && src_list.size() != 0) begin
      if (pkt_hs) begin
        s = src_list.pop_front();
        stall = 0;
      end else begin
        stall++;
        if (stall >= 3) begin
          s = src_list.pop_front();
          src_list.push_back(s);
          stall = 0;
        end
      end
    end
  endtask

  task automatic drive();
    int         r;
    int         cand [$];
    logic [3:0] s;
    if (mode == M_DIRECT) begin
      pkt_valid  = (src_list.size() != 0);
      pkt_src    = pkt_valid ? src_list[0] : 4'b0001;
      acc_ready  = 1'b1;
      flag_ready = 1'b1;
      done_ready = 1'b1;
    end else begin
      r = 32'($urandom_range(0, 99));
      if (r < 10) begin
        if (r < 5) s = 4'b0000;
        else begin
          do s = 4'($urandom); while (pe_idx(s) >= 0);
        end
      end else if (r < 15) begin
        s = pe_addr[$urandom_range(0, 4)];
      end else begin
        for (int i = 0; i < 5; i++) if (cnt[i] < SLOTS) cand.push_back(i);
        if (cand.size() == 0) s = pe_addr[$urandom_range(0, 4)];
        else s = pe_addr[cand[$urandom_range(0, 32'(cand.size() - 1))]];
      end
      pkt_src   = s;
      pkt_valid = ($urandom_range(0, 3) != 0);
      if (hold_cnt == 0 && exp_q.size() != 0 && exp_q[0].kind == 0 && $urandom_range(0, 24) == 0)
        hold_cnt = 10;
      if (hold_cnt > 0) begin
        hold_cnt--;
        acc_ready = 1'b0;
      end else begin
        acc_ready = ($urandom_range(0, 3) != 0);
      end
      flag_ready = ($urandom_range(0, 2) != 0);
      done_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    step();
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_pkt_ready"}, 32'(pkt_ready), 0);
    check_eq({tag, "_acc_valid"}, 32'(acc_valid), 0);
    check_eq({tag, "_flag_valid"}, 32'(flag_valid), 0);
    check_eq({tag, "_done_valid"}, 32'(done_valid), 0);
    check_eq({tag, "_err_src"}, 32'(err_src), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pkt_valid = 1'b0; pkt_src = 4'b0001;
    acc_ready = 1'b0; flag_ready = 1'b0; done_ready = 1'b0;
    #1;
    check_quiet("rst_now");
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_quiet("rst_hold");
    end
    rst_n = 1'b1;
    #1;
    check_eq("rdy_after_rst", 32'(pkt_ready), 1);
  endtask

  task automatic load_rr(input bit with_unknown);
    src_list.delete();
    if (with_unknown) src_list.push_back(4'b0000);
    for (int r = 0; r < SLOTS; r++)
      for (int i = 0; i < 5; i++) src_list.push_back(pe_addr[i]);
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(src_list.size() == 0 && exp_q.size() == 0) && n < budget);
    check_eq({tag, "_timeout"}, 32'(n >= budget), 0);
  endtask

  initial begin
    int  n;
    bit  found;
    mode = M_DIRECT;
    apply_reset();

    // Round-robin round with one unknown-source packet up front.
    load_rr(1'b1);
    run_idle(300, "rr1");

    // A fourth PE1 packet ahead of the rest of the round.
    src_list.delete();
    for (int i = 0; i < 4; i++) src_list.push_back(pe_addr[0]);
    for (int r = 0; r < SLOTS; r++)
      for (int i = 1; i < 5; i++) src_list.push_back(pe_addr[i]);
    repeat (120) cycle();
    src_list.delete();

    // Random traffic across a full timestep and into the next.
    mode = M_RANDOM;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(acc_seq >= 70 && exp_q.size() == 0) && n < 20000);
    check_eq("rand_timeout", 32'(n >= 20000), 0);

    // Abort the third flag transfer with reset.
    n = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      cycle();
      n++;
      if (exp_q.size() != 0 && !gap && exp_q[0].kind == 1 && flag_run == 2) found = 1'b1;
    end
    check_eq("flag3_timeout", 32'(found), 1);
    if (found) begin
      @(posedge clk);
      #2;
      check_eq("flag3_valid", 32'(flag_valid), 1);
      check_eq("flag3_dst", 32'(flag_dst), exp_q[0].dst);
      flag_ready = 1'b1;
      #1;
    end
    mode = M_DIRECT;
    apply_reset();
    load_rr(1'b0);
    run_idle(300, "rr_post_rst");

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/partial_sum_sequencer.md
PARTIAL_SUM_SEQUENCER -- requirements
Module: partial_sum_sequencer

Interface
REQ-001 SHALL have parameter NUM_PE, default 5: number of PE partial-sum sources.
REQ-002 SHALL have parameter SLOTS, default 3: partial sums per PE per collection round.
REQ-003 SHALL have parameter ROWS, default 21, and COLS, default 3: neuron grid served by one adder.
REQ-004 SHALL have parameter SEND_FLAGS, default 1: emit per-row flag packets to PEs when 1.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports pkt_valid input 1, pkt_ready output 1, pkt_src input 4: incoming partial-sum header (source PE address).
REQ-008 SHALL have ports acc_valid output 1, acc_ready input 1, acc_slot output 2, acc_row output 5, acc_col output 2, acc_first_ts output 1: accumulate command to adder datapath.
REQ-009 SHALL have ports flag_valid output 1, flag_ready input 1, flag_dst output 4: row-complete flag request.
REQ-010 SHALL have ports done_valid output 1, done_ready input 1: timestep-complete request.
REQ-011 SHALL have port err_src output 1: one-cycle pulse on unknown pkt_src.

Function
REQ-012 SHALL map PE addresses PE1=0001, PE2=0101, PE3=0011, PE4=0111, PE5=1100 to counter indices 0..4.
REQ-013 SHALL use valid/ready handshakes; transfer occurs on a rising edge with both high; valid outputs SHALL hold, with stable payload, until transfer.
REQ-014 SHALL implement FSM states COLLECT, ACCUM, FLAG, DONE; reset state COLLECT.
REQ-015 COLLECT: pkt_ready = 1 if pkt_src is unknown, or known and its counter < SLOTS; else 0 (backpressure, no drop).
REQ-016 Known-source transfer SHALL increment that PE's 2-bit counter; unknown-source transfer SHALL be consumed, counters unchanged, err_src pulsed next cycle.
REQ-017 When all counters equal SLOTS, FSM SHALL enter ACCUM the next cycle with acc_slot=0; pkt_ready SHALL be 0 outside COLLECT.
REQ-018 ACCUM: acc_valid=1; acc_row/acc_col give current neuron; acc_first_ts=1 until first DONE transfer, then 0 until reset.
REQ-019 On acc transfer: col increments; col==COLS-1 wraps to 0 and row increments; row==ROWS-1 with col wrap wraps both to 0; entry count increments.
REQ-020 After acc transfer, priority: column wrap and SEND_FLAGS=1 -> FLAG; else entry count == ROWS*COLS -> DONE; else acc_slot==SLOTS-1 -> COLLECT with all counters cleared; else ACCUM with acc_slot+1.
REQ-021 FLAG: flag_dst sequence PE4, PE3, PE2, PE1, PE5, one per transfer; after fifth, apply REQ-020 remaining priorities.
REQ-022 DONE: done_valid=1; on transfer clear entry count, clear acc_first_ts, then COLLECT with counters cleared (if acc_slot==SLOTS-1) else ACCUM slot+1.
REQ-023 Entry count SHALL be 7 bits, terminal ROWS*COLS (63), no overflow past it.
REQ-024 At most one of acc_valid, flag_valid, done_valid SHALL be high in any cycle.

Reset
REQ-025 rst_n low SHALL immediately force: state COLLECT, all counters, row, col, slot, entry count 0, acc_first_ts 1, all valids 0, err_src 0, pkt_ready 0 during reset.
REQ-026 Reset mid-handshake SHALL abandon the transfer; no partial state retained after release.
REQ-027 First pkt_ready=1 SHALL appear in the first cycle after rst_n deasserts.

Structure
REQ-028 Shared package ps_pkg SHALL hold PE address constants, FSM state enum, and flag order table.
REQ-029 A sub-module pe_arrival_tracker (per-PE counters, all-full detect, source decode) SHALL be instantiated once.

Verification
REQ-030 Round-robin PE1..PE5 packets x3, all readies high -> acc slots 0,1,2 at row0 col0..2, then 5 flags 0111,0011,0101,0001,1100, then COLLECT.
REQ-031 Fourth PE1 packet before round completes -> pkt_ready=0 for PE1 while PE2..PE5 still accepted.
REQ-032 pkt_src=0000 -> consumed, err_src one-cycle pulse, counters unchanged.
REQ-033 21 full rounds -> done_valid after 63rd acc's flags; next round acc_first_ts=0, row/col restart at 0.
REQ-034 acc_ready held low 10 cycles -> acc_valid and payload stable; no flag/done valid concurrently.
REQ-035 rst_n low during FLAG third transfer -> all valids 0 immediately; after release, fresh round starts at row0 col0, acc_first_ts=1.
